// File: rtl/fp_pkg.sv
// Shared constants, FSM state encoding and packed result layout for the FP normalise/round block.
package fp_pkg;

    localparam int unsigned BIAS      = 127;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned FRAC_W    = 23;
    localparam int unsigned EXP_MAX   = 255;
    localparam int unsigned EXP_SUM_W = 10;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_NORM  = 3'd1;
    localparam state_t S_ROUND = 3'd2;
    localparam state_t S_PACK  = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_norm_round_rne.sv
// Round-to-nearest-even increment of a fraction using its guard and sticky bits.
module round_rne
    import fp_pkg::*;
(
    input  logic [FRAC_W-1:0] frac,
    input  logic              guard,
    input  logic              sticky,
    output logic [FRAC_W-1:0] frac_rnd_c,
    output logic              carry_c
);

    // Ties go to the even fraction: bump only when past half, or at half with an odd LSB.
    always_comb begin
        {carry_c, frac_rnd_c} = {1'b0, frac} + (FRAC_W+1)'(guard & (sticky | frac[0]));
    end

endmodule

// File: rtl/fp_norm_round.sv
// Normalises a raw mantissa product, rounds it and packs an IEEE-754 single.
// Define FP_NORM_ROUND_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int unsigned N = 48,
    parameter int unsigned M = 24,
    parameter int unsigned E = 8
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Start,
    input  logic [N-1:0] Product,
    input  logic         SignA,
    input  logic         SignB,
    input  logic [E-1:0] ExpA,
    input  logic [E-1:0] ExpB,
    output logic [31:0]  Result,
    output logic         Done,
    output logic         Busy,
    output logic         Overflow,
    output logic         Underflow
);

    // Product of two M-bit mantissas has its value-2.0 bit here.
    localparam int unsigned TOP = 2*M - 1;

`ifdef FP_NORM_ROUND_RNE_EN
    localparam int unsigned KEEP_W = TOP + 1;
`else
    // Truncation only ever needs the top bit and both candidate fractions.
    localparam int unsigned KEEP_W = FRAC_W + 2;
`endif

    localparam logic signed [EXP_SUM_W-1:0] EXP_TOP  = EXP_SUM_W'(EXP_MAX);
    localparam logic signed [EXP_SUM_W-1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_SUM_W-1:0] EXP_ONE  = EXP_SUM_W'(1);

    state_t                       state_q, state_d;
    logic [KEEP_W-1:0]            keep_q, keep_d;
    logic                         sign_q, sign_d;
    logic                         zero_q, zero_d;
    logic signed [EXP_SUM_W-1:0]  exp_q, exp_d;
    logic [FRAC_W-1:0]            frac_q, frac_d;
    fp32_t                        result_q, result_d;
    logic                         ovf_q, ovf_d;
    logic                         unf_q, unf_d;
    logic                         done_q, done_d;
    logic                         busy_q, busy_d;

`ifdef FP_NORM_ROUND_RNE_EN
    logic                         guard_q, guard_d;
    logic                         sticky_q, sticky_d;
    logic [FRAC_W-1:0]            frac_rnd_c;
    logic                         carry_c;

    round_rne u_round_rne (
        .frac       (frac_q),
        .guard      (guard_q),
        .sticky     (sticky_q),
        .frac_rnd_c (frac_rnd_c),
        .carry_c    (carry_c)
    );
`endif

    // Next-state and datapath updates; every register holds unless its state acts on it.
    always_comb begin
        state_d  = state_q;
        keep_d   = keep_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        exp_d    = exp_q;
        frac_d   = frac_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
`ifdef FP_NORM_ROUND_RNE_EN
        guard_d  = guard_q;
        sticky_d = sticky_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_NORM;
                    keep_d  = Product[TOP -: KEEP_W];
                    sign_d  = SignA ^ SignB;
                    zero_d  = (Product == '0);
                    exp_d   = $signed(EXP_SUM_W'(ExpA) + EXP_SUM_W'(ExpB) - EXP_SUM_W'(BIAS));
                end
            end

            S_NORM: begin
                state_d = S_ROUND;
                if (keep_q[KEEP_W-1]) begin
                    frac_d   = keep_q[KEEP_W-2 -: FRAC_W];
                    exp_d    = exp_q + EXP_ONE;
`ifdef FP_NORM_ROUND_RNE_EN
                    guard_d  = keep_q[KEEP_W-2-FRAC_W];
                    sticky_d = |keep_q[KEEP_W-3-FRAC_W:0];
`endif
                end else begin
                    frac_d   = keep_q[KEEP_W-3 -: FRAC_W];
`ifdef FP_NORM_ROUND_RNE_EN
                    guard_d  = keep_q[KEEP_W-3-FRAC_W];
                    sticky_d = |keep_q[KEEP_W-4-FRAC_W:0];
`endif
                end
            end

            S_ROUND: begin
                state_d = S_PACK;
`ifdef FP_NORM_ROUND_RNE_EN
                frac_d = frac_rnd_c;
                if (carry_c) begin
                    exp_d = exp_q + EXP_ONE;
                end
`endif
            end

            S_PACK: begin
                state_d = S_DONE;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                if (zero_q) begin
                    result_d = '{sign: sign_q, exp: '0, frac: '0};
                end else if (exp_q >= EXP_TOP) begin
                    result_d = '{sign: sign_q, exp: '1, frac: '0};
                    ovf_d    = 1'b1;
                end else if (exp_q <= EXP_ZERO) begin
                    result_d = '{sign: sign_q, exp: '0, frac: '0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = '{sign: sign_q, exp: exp_q[EXP_W-1:0], frac: frac_q};
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            keep_q   <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            exp_q    <= '0;
            frac_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef FP_NORM_ROUND_RNE_EN
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            keep_q   <= keep_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            exp_q    <= exp_d;
            frac_q   <= frac_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef FP_NORM_ROUND_RNE_EN
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
`endif
        end
    end

    assign Result    = result_q;
    assign Done      = done_q;
    assign Busy      = busy_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 The block SHALL have parameter N, default 48, meaning the width of the raw mantissa product.
REQ-002 The block SHALL have parameter M, default 24, meaning the operand mantissa width including the hidden bit.
REQ-003 The block SHALL have parameter E, default 8, meaning the exponent width.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port Start, input, 1 bit: a one-cycle pulse from the upstream multiplier's completion.
REQ-007 The block SHALL have port Product, input, N bits: the unsigned mantissa product, valid in the Start cycle.
REQ-008 The block SHALL have ports SignA and SignB, input, 1 bit each: the operand signs.
REQ-009 The block SHALL have ports ExpA and ExpB, input, E bits each: the biased operand exponents.
REQ-010 The block SHALL have port Result, output, 32 bits: the packed IEEE-754 single-precision result.
REQ-011 The block SHALL have port Done, output, 1 bit: a one-cycle pulse indicating Result is valid.
REQ-012 The block SHALL have port Busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have ports Overflow and Underflow, output, 1 bit each: sticky exception flags for the current result.

Function
REQ-014 The FSM SHALL have states IDLE, NORM, ROUND, PACK and DONE, and SHALL advance exactly one state per clock edge after leaving IDLE.
REQ-015 In IDLE, a high Start SHALL capture Product, SignA^SignB and the 10-bit signed sum ExpA+ExpB-127, then move to NORM; Start SHALL be ignored in every other state.
REQ-016 In NORM:
- if Product[N-1]=1: frac=Product[46:24], guard=Product[23], sticky=|Product[22:0], exp=exp+1;
- otherwise: frac=Product[45:23], guard=Product[22], sticky=|Product[21:0].
REQ-017 In ROUND, round-to-nearest-even SHALL apply: increment frac when guard & (sticky | frac[0]).
REQ-018 A rounding carry out of frac SHALL set frac=0 and exp=exp+1.
REQ-019 In PACK:
- exp >= 255: Result={sign,8'hFF,23'h0} and Overflow=1;
- exp <= 0: Result={sign,31'h0} (flush to zero) and Underflow=1;
- otherwise: Result={sign,exp[7:0],frac}.
REQ-020 A Product of 0 SHALL yield the signed zero {sign,31'h0} with both flags 0.
REQ-021 In DONE, Done SHALL be 1 for exactly one cycle, the state SHALL then return to IDLE, and Done SHALL fall 4 edges after the edge that sampled Start.
REQ-022 Result, Overflow and Underflow SHALL hold their values until PACK of the next operation.
REQ-023 A Start arriving in the same cycle as DONE SHALL be ignored.

Reset
REQ-024 While Reset=0, the state SHALL be IDLE and Result=0, Done=0, Busy=0, Overflow=0 and Underflow=0, irrespective of CLK.
REQ-025 A Reset mid-operation SHALL abort the operation with no Done pulse, and the first Start after release SHALL be processed normally.

Configuration
REQ-026 With macro FP_NORM_ROUND_RNE_EN defined, the ROUND state SHALL perform REQ-017 and REQ-018.
REQ-027 With FP_NORM_ROUND_RNE_EN undefined, ROUND SHALL truncate (frac unchanged, guard and sticky discarded) while latency stays 4 edges.

Structure
REQ-028 A shared package fp_pkg SHALL hold BIAS=127, EXP_W=8, FRAC_W=23, EXP_MAX=255 and the FSM state typedef.
REQ-029 Guard/sticky rounding SHALL be a combinational sub-module named round_rne, instantiated only under FP_NORM_ROUND_RNE_EN.

Verification
REQ-030 Test 1.0x1.0: Product=48'h4000_0000_0000, ExpA=ExpB=127, signs 0 -> Result=32'h3F80_0000, Done 4 edges after Start, both flags 0.
REQ-031 Test 1.5x1.5: Product=48'h9000_0000_0000, ExpA=ExpB=127 -> Result=32'h4010_0000 (2.25).
REQ-032 Test tie rounding: Product=48'h4000_00C0_0000, exps 127 -> Result=32'h3F80_0002 with the macro, 32'h3F80_0001 without it.
REQ-033 Test overflow: ExpA=ExpB=254, SignA=1, Product=48'h4000_0000_0000 -> Result=32'hFF80_0000, Overflow=1.
REQ-034 Test underflow: ExpA=ExpB=10 -> Result=32'h0000_0000, Underflow=1.
REQ-035 Test reset abort: Reset pulled low in ROUND -> no Done pulse, all outputs 0; Start 2 cycles after release -> correct result.
